// File: rtl/strig_capture.sv
// strig_capture: self-triggered ADC window capture with a circular pre-trigger history buffer.
// Defining STRIG_CAP_HDR_EN prefixes each window with a header word carrying the latched tcount.
module strig_capture #(
   parameter int unsigned WINLEN  = 32,
   parameter int unsigned PRETRIG = 8,
   parameter int unsigned BBITS   = 6
) (
   input  logic               adcclk,
   input  logic               adcrst_n,
   input  logic signed [15:0] data,
   input  logic               trig,
   input  logic [9:0]         tcount,
   input  logic               inhibit,
   output logic [15:0]        dout,
   output logic               dvalid,
   input  logic               dready,
   output logic               dlast,
   output logic               busy,
   output logic [9:0]         lost
);

`ifdef STRIG_CAP_HDR_EN
   localparam int unsigned HDR = 1;
`else
   localparam int unsigned HDR = 0;
`endif

   localparam int unsigned CW = BBITS + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_POST  = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_REARM = 2'd3;

   localparam logic [CW-1:0]    ONE     = CW'(1);
   localparam logic [CW-1:0]    POST_N  = CW'(WINLEN - PRETRIG);
   localparam logic [CW-1:0]    PRE_N   = CW'(PRETRIG);
   localparam logic [CW-1:0]    WORDS_N = CW'(WINLEN + HDR);
   localparam logic [BBITS-1:0] PRE_OFF = BBITS'(PRETRIG);
   localparam logic [BBITS-1:0] PTR_ONE = BBITS'(1);

   logic [15:0]      mem [0:(2**BBITS)-1];
   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [BBITS-1:0] wptr;
   logic [BBITS-1:0] rptr;
   logic             we;
   logic             load;
   logic             xfer;
   logic             accept;
   logic [15:0]      word;
   logic             rd_adv;

   assign busy   = (state != S_IDLE);
   assign xfer   = dvalid && dready;
   assign accept = (state == S_IDLE) && trig && !inhibit;
   // cnt doubles as the index of the next word to present while in SEND
   assign load   = (state == S_SEND) && (cnt < WORDS_N) && (!dvalid || dready);

   // The trig-cycle sample is written in IDLE, so POST stops writing once the
   // post-trigger count is reached; this keeps sample 0 intact when WINLEN == 2^BBITS.
   always_comb begin
      we = 1'b0;
      case (state)
         S_POST:  we = (cnt < POST_N);
         S_SEND:  we = 1'b0;
         default: we = 1'b1;
      endcase
   end

   always_ff @(posedge adcclk) begin
      if (we) mem[wptr] <= data;
   end

`ifdef STRIG_CAP_HDR_EN
   logic [9:0] tlatch;

   always_ff @(posedge adcclk or negedge adcrst_n) begin
      if (!adcrst_n)   tlatch <= '0;
      else if (accept) tlatch <= tcount;
   end

   assign word   = (cnt == '0) ? {4'hA, 2'b00, tlatch} : mem[rptr];
   assign rd_adv = (cnt != '0);
`else
   // tcount only feeds the header word
   logic unused_tcount;
   assign unused_tcount = ^tcount;
   assign word   = mem[rptr];
   assign rd_adv = 1'b1;
`endif

   always_ff @(posedge adcclk or negedge adcrst_n) begin
      if (!adcrst_n) begin
         state  <= S_REARM;
         cnt    <= '0;
         wptr   <= '0;
         rptr   <= '0;
         dout   <= '0;
         dvalid <= 1'b0;
         dlast  <= 1'b0;
         lost   <= '0;
      end else begin
         if (trig && (state != S_IDLE)) lost <= lost + 10'd1;
         if (we) wptr <= wptr + PTR_ONE;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_POST;
                  cnt   <= ONE;
                  rptr  <= wptr - PRE_OFF;
               end
            end
            S_POST: begin
               cnt <= cnt + ONE;
               if ((cnt + ONE) >= POST_N) begin
                  state <= S_SEND;
                  cnt   <= '0;
               end
            end
            S_SEND: begin
               if (load) begin
                  dout   <= word;
                  dvalid <= 1'b1;
                  dlast  <= (cnt == (WORDS_N - ONE));
                  cnt    <= cnt + ONE;
                  if (rd_adv) rptr <= rptr + PTR_ONE;
               end else if (xfer) begin
                  dvalid <= 1'b0;
               end
               if (xfer && dlast) begin
                  state <= S_REARM;
                  cnt   <= '0;
                  dlast <= 1'b0;
               end
            end
            S_REARM: begin
               cnt <= cnt + ONE;
               if ((cnt + ONE) >= PRE_N) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_strig_capture.sv
// Bench for strig_capture: directed trigger scenarios with ramp/random data and random backpressure,
// scored against a window-level model built from the sample history. Honours STRIG_CAP_HDR_EN.
module tb_strig_capture;

   localparam int unsigned WINLEN  = 32;
   localparam int unsigned PRETRIG = 8;
   localparam int unsigned BBITS   = 6;
`ifdef STRIG_CAP_HDR_EN
   localparam int unsigned HDR = 1;
`else
   localparam int unsigned HDR = 0;
`endif
   localparam int unsigned NW    = WINLEN + HDR;
   localparam int unsigned POSTN = WINLEN - PRETRIG;
   localparam int unsigned PMIN  = (PRETRIG == 0) ? 1 : PRETRIG;

   logic               adcclk = 1'b0;
   logic               adcrst_n = 1'b1;
   logic signed [15:0] data = '0;
   logic               trig = 1'b0;
   logic [9:0]         tcount = '0;
   logic               inhibit = 1'b0;
   logic [15:0]        dout;
   logic               dvalid;
   logic               dready = 1'b1;
   logic               dlast;
   logic               busy;
   logic [9:0]         lost;

   strig_capture #(.WINLEN(WINLEN), .PRETRIG(PRETRIG), .BBITS(BBITS)) dut (
      .adcclk(adcclk), .adcrst_n(adcrst_n), .data(data), .trig(trig), .tcount(tcount),
      .inhibit(inhibit), .dout(dout), .dvalid(dvalid), .dready(dready), .dlast(dlast),
      .busy(busy), .lost(lost)
   );

   always #5 adcclk = ~adcclk;

   // Reference model state: sample history by edge number plus the window being delivered.
   logic [15:0] hist [4096];
   int unsigned cyc = 0;
   int unsigned ready = 32'h4000_0000;
   int unsigned r0 = 0;
   int unsigned wstart = 0;
   int unsigned k = 0;
   int unsigned deadline = 0;
   int unsigned trig_n = 0;
   int unsigned ndl = 0;
   logic        inwin = 1'b0;
   logic [9:0]  m_lost = '0;
   logic [9:0]  m_tc = '0;
   logic [15:0] first_w = '0;
   logic [15:0] last_w = '0;
   int unsigned rdy_mode = 0;
   logic        ramp_mode = 1'b1;
   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input int unsigned kk);
      int unsigned idx;
      if (HDR == 1 && kk == 0) return {4'hA, 2'b00, m_tc};
      idx = wstart + kk - HDR;
      return hist[idx[11:0]];
   endfunction

   task automatic step(input logic t_in, input logic [9:0] tc_in, input logic inh_in);
      int unsigned n;
      logic        busy_now;
      logic        stall;
      logic [15:0] sdout;
      logic        sdlast;
      n = cyc + 1;
      stall = 1'b0;
      sdout = '0;
      sdlast = 1'b0;
      trig = t_in;
      tcount = tc_in;
      inhibit = inh_in;
      case (rdy_mode)
         0:       dready = 1'b1;
         1:       dready = ($urandom_range(0, 3) != 0);
         default: dready = 1'b0;
      endcase
      if (ramp_mode) data = n[15:0];
      else           data = 16'($urandom);
      hist[n[11:0]] = data;
      busy_now = inwin || (n < ready);
      if (dvalid) begin
         chk("dvalid_in_window", 32'(inwin), 32'd1);
         if (dready && inwin) begin
            chk("dout", 32'(dout), 32'(exp_word(k)));
            chk("dlast", 32'(dlast), 32'(k == NW - 1));
            if (k == 0) first_w = dout;
            if (dlast) begin
               ndl++;
               last_w = dout;
            end
            k++;
            if (k == NW) begin
               inwin = 1'b0;
               ready = n + 1 + PMIN;
            end
         end else if (!dready) begin
            stall = 1'b1;
            sdout = dout;
            sdlast = dlast;
         end
      end
      if (t_in && busy_now) begin
         m_lost = m_lost + 10'd1;
      end else if (t_in && !inh_in) begin
         inwin = 1'b1;
         k = 0;
         wstart = n - PRETRIG;
         m_tc = tc_in;
         trig_n = n;
         deadline = n + POSTN - 1 + 3;
      end
      @(posedge adcclk);
      #1;
      cyc = n;
      if (stall) begin
         chk("stall_dvalid", 32'(dvalid), 32'd1);
         chk("stall_dout", 32'(dout), 32'(sdout));
         chk("stall_dlast", 32'(dlast), 32'(sdlast));
      end
      chk("busy", 32'(busy), 32'(inwin || (n + 1 < ready)));
      chk("lost", 32'(lost), 32'(m_lost));
      if (rdy_mode == 0 && inwin && k > 0) chk("no_bubble", 32'(dvalid), 32'd1);
      if (inwin && n == deadline) chk("first_latency", 32'((k > 0) || dvalid), 32'd1);
   endtask

   task automatic do_reset(input int unsigned nlow);
      #1 adcrst_n = 1'b0;
      #1;
      chk("rst_dvalid", 32'(dvalid), 32'd0);
      chk("rst_dlast", 32'(dlast), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_lost", 32'(lost), 32'd0);
      inwin = 1'b0;
      m_lost = '0;
      ready = 32'h4000_0000;
      repeat (nlow) step(1'b0, '0, 1'b0);
      adcrst_n = 1'b1;
      r0 = cyc + 1;
      ready = r0 + PMIN;
   endtask

   task automatic run_to_ready();
      for (int i = 0; i < 400 && (inwin || cyc + 1 < ready); i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic wait_done(input int unsigned limit);
      for (int unsigned i = 0; i < limit && inwin; i++) step(1'b0, '0, 1'b0);
      chk("window_done", 32'(inwin), 32'd0);
   endtask

   initial begin
      logic [9:0]  lb;
      int unsigned nb;
      int unsigned exp_l;

      do_reset(3);
      run_to_ready();
      repeat (5) step(1'b0, '0, 1'b0);

      // Inhibited trigger in IDLE: nothing happens
      step(1'b1, 10'd7, 1'b1);
      repeat (10) step(1'b0, '0, 1'b0);
      chk("inhibit_busy", 32'(busy), 32'd0);
      chk("inhibit_lost", 32'(lost), 32'd0);
      chk("inhibit_no_dlast", ndl, 32'd0);

      // Ramp window, trigger on ramp value 100, full-rate consumer
      while (cyc < 99) step(1'b0, '0, 1'b0);
      step(1'b1, 10'd5, 1'b0);
      wait_done(200);
      chk("ramp_first_word", 32'(first_w), (HDR == 1) ? 32'h0000_A005 : 32'd92);
      chk("ramp_last_word", 32'(last_w), 32'd123);

      // Same window shape under random backpressure
      rdy_mode = 1;
      run_to_ready();
      step(1'b1, 10'd5, 1'b0);
      wait_done(600);
      chk("bp_last_word", 32'(last_w), 32'((trig_n + POSTN - 1) & 32'hFFFF));

      // Extra triggers during POST and REARM are dropped and counted
      rdy_mode = 0;
      run_to_ready();
      lb = lost;
      nb = ndl;
      step(1'b1, 10'd3, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
      step(1'b1, 10'd4, 1'b0);
      wait_done(200);
      step(1'b1, 10'd9, 1'b0);
      repeat (PMIN + 20) step(1'b0, '0, 1'b0);
      chk("drop_lost_delta", 32'(10'(lost - lb)), 32'd2);
      chk("drop_one_window", ndl - nb, 32'd1);

      // Random data, random backpressure, random tcount
      ramp_mode = 1'b0;
      rdy_mode = 1;
      run_to_ready();
      step(1'b1, 10'($urandom), 1'b0);
      wait_done(600);

      // Long stall with trig held high: lost wraps at 1024, dout stays put
      rdy_mode = 2;
      run_to_ready();
      step(1'b1, 10'd1, 1'b0);
      for (int i = 0; i < 60 && !dvalid; i++) step(1'b0, '0, 1'b0);
      chk("stall_first_valid", 32'(dvalid), 32'd1);
      lb = lost;
      repeat (1030) step(1'b1, '0, 1'b0);
      exp_l = (32'(lb) + 1030) % 1024;
      chk("lost_wrap", 32'(lost), exp_l);
      rdy_mode = 1;
      wait_done(600);

      // Reset mid-SEND, trigger during refill, then a window straddling the buffer wrap
      ramp_mode = 1'b1;
      rdy_mode = 0;
      run_to_ready();
      step(1'b1, 10'd2, 1'b0);
      for (int i = 0; i < 80 && k < 5; i++) step(1'b0, '0, 1'b0);
      nb = ndl;
      do_reset(2);
      repeat (3) step(1'b0, '0, 1'b0);
      step(1'b1, 10'd0, 1'b0);
      chk("refill_trig_lost", 32'(lost), 32'd1);
      while (cyc + 1 < r0 + 68) step(1'b0, '0, 1'b0);
      step(1'b1, 10'd63, 1'b0);
      wait_done(200);
      chk("wrap_window_count", ndl - nb, 32'd1);
      chk("wrap_first_word", 32'(first_w), (HDR == 1) ? 32'h0000_A03F : 32'((r0 + 60) & 32'hFFFF));
      chk("wrap_last_word", 32'(last_w), 32'((r0 + 68 + POSTN - 1) & 32'hFFFF));
      repeat (PMIN + 4) step(1'b0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
